fun_sweeper: RTL and testbench



---
 rtl/fun_sweeper_if.sv | 21 ++
 rtl/fun_sweeper.sv | 140 ++++++++++++++
 tb/tb_fun_sweeper.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fun_sweeper_if.sv
// Stimulus/response link between fun_sweeper and the fun gate under test.
interface fun_sweeper_if;
    logic a;
    logic b;
    logic c;
    logic y;

    modport master (
        output a,
        output b,
        output c,
        input  y
    );

    modport slave (
        input  a,
        input  b,
        input  c,
        output y
    );
endinterface

// File: rtl/fun_sweeper.sv
// Exhaustive sweeper/checker for y = (a | b) & ~c.
// Define FUN_SWEEP_LOOP_EN for continuous sweeping with sticky results.
module fun_sweeper #(
    parameter int SETTLE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    fun_sweeper_if.master  fun,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [3:0]     err_cnt,
    output logic [7:0]     fail_mask,
    output logic [7:0]     led
);

    localparam int CW = 16;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        CHECK,
        HOLD,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic          clr;
    logic          chk;
    logic          nxt;
    logic          fin;
    logic          rewind;
    logic          exp_y;

    assign exp_y = (idx[2] | idx[1]) & ~idx[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        clr      = 1'b0;
        chk      = 1'b0;
        nxt      = 1'b0;
        fin      = 1'b0;
        rewind   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    clr      = 1'b1;
                    state_nx = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == CW'(SETTLE_CYCLES - 1))
                    state_nx = CHECK;
            end
            CHECK: begin
                chk      = 1'b1;
                state_nx = HOLD;
            end
            HOLD: begin
                if (cnt == CW'(HOLD_CYCLES - 1)) begin
                    if (idx == 3'd7) begin
                        fin      = 1'b1;
                        state_nx = DONE;
                    end else begin
                        nxt      = 1'b1;
                        state_nx = SETTLE;
                    end
                end
            end
            DONE: begin
`ifdef FUN_SWEEP_LOOP_EN
                rewind   = 1'b1;
                state_nx = SETTLE;
`else
                state_nx = IDLE;
`endif
            end
            default: state_nx = IDLE;
        endcase
    end

    // Phase counter restarts on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (state_nx != state)
            cnt <= '0;
        else if (state == SETTLE || state == HOLD)
            cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            err_cnt   <= '0;
            fail_mask <= '0;
            pass      <= 1'b0;
        end else begin
            if (clr) begin
                idx       <= '0;
                err_cnt   <= '0;
                fail_mask <= '0;
                pass      <= 1'b0;
            end
            if (rewind)
                idx <= '0;
            if (nxt)
                idx <= idx + 1'b1;
            if (chk && (fun.y != exp_y)) begin
                fail_mask[idx] <= 1'b1;
                if (err_cnt != 4'hF)
                    err_cnt <= err_cnt + 1'b1;
            end
            // err_cnt is final here, vector 7 included.
            if (fin)
                pass <= (err_cnt == 4'h0);
        end
    end

    assign fun.a = idx[2];
    assign fun.b = idx[1];
    assign fun.c = idx[0];

    assign busy = (state == SETTLE) ||
                  (state == CHECK)  ||
                  (state == HOLD);
    assign done = (state == DONE);
    assign led  = busy ? (8'b1 << idx) : 8'h00;

endmodule

// File: tb/tb_fun_sweeper.sv
// Directed bench for fun_sweeper with golden and stuck-at y sources.
// Build with FUN_SWEEP_LOOP_EN to exercise the looping variant.
module tb_fun_sweeper;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_cnt;
    logic [7:0] fail_mask;
    logic [7:0] led;
    int         mode;
    int         n_cmp;
    int         n_bad;

    fun_sweeper_if bus ();

    // 0: golden gate, 1: y stuck at 0, 2: y stuck at 1
    assign bus.y = (mode == 0) ? ((bus.a | bus.b) & ~bus.c) :
                   (mode == 2);

    fun_sweeper dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .fun       (bus),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_cnt   (err_cnt),
        .fail_mask (fail_mask),
        .led       (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset;
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic launch(input bit hold);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) start = 1'b0;
    endtask

    // Called at the first negedge after start was sampled (k = 0).
    task automatic watch_sweep(input string name);
        logic [7:0] exp_led;
        logic [2:0] exp_abc;
        for (int k = 0; k < 88; k++) begin
            exp_led = 8'(1) << (k / 11);
            exp_abc = 3'(k / 11);
            n_cmp++;
            if (busy !== 1'b1 || done !== 1'b0 || led !== exp_led ||
                {bus.a, bus.b, bus.c} !== exp_abc) begin
                n_bad++;
                $display("FAIL %s walk k=%0d busy=%b done=%b led=%h abc=%0d want 1/0/%h/%0d",
                         name, k, busy, done, led, {bus.a, bus.b, bus.c},
                         exp_led, exp_abc);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0 || led !== 8'h00) begin
            n_bad++;
            $display("FAIL %s done_pulse done=%b busy=%b led=%h want 1/0/00",
                     name, done, busy, led);
        end
    endtask

    task automatic check_results(input string name, input logic [7:0] m,
                                 input logic [3:0] e, input logic p);
        n_cmp++;
        if (fail_mask !== m || err_cnt !== e || pass !== p) begin
            n_bad++;
            $display("FAIL %s results mask=%h err=%0d pass=%b want %h/%0d/%b",
                     name, fail_mask, err_cnt, pass, m, e, p);
        end
    endtask

    task automatic check_idle(input string name);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 ||
            err_cnt !== 4'h0 || fail_mask !== 8'h00 || led !== 8'h00 ||
            {bus.a, bus.b, bus.c} !== 3'b000) begin
            n_bad++;
            $display("FAIL %s reset_vals busy=%b done=%b pass=%b err=%0d mask=%h led=%h abc=%b want all 0",
                     name, busy, done, pass, err_cnt, fail_mask, led,
                     {bus.a, bus.b, bus.c});
        end
    endtask

    task automatic test_reset;
        mode = 0;
        do_reset();
        check_idle("reset");
        repeat (5) @(negedge clk);
        check_idle("reset_no_start");
    endtask

    task automatic test_sweep(input string name, input int m,
                              input logic [7:0] em, input logic [3:0] ee,
                              input logic ep);
        mode = m;
        do_reset();
        launch(1'b0);
        watch_sweep(name);
        check_results(name, em, ee, ep);
        @(negedge clk);
        n_cmp++;
`ifdef FUN_SWEEP_LOOP_EN
        if (done !== 1'b0 || busy !== 1'b1) begin
`else
        if (done !== 1'b0 || busy !== 1'b0) begin
`endif
            n_bad++;
            $display("FAIL %s after_done done=%b busy=%b", name, done, busy);
        end
    endtask

`ifndef FUN_SWEEP_LOOP_EN
    task automatic test_start_held;
        int dones;
        mode = 2;
        do_reset();
        launch(1'b1);
        watch_sweep("held");
        check_results("held_first", 8'hAB, 4'd5, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL held_gap busy=%b done=%b want 0/0", busy, done);
        end
        @(negedge clk);
        mode  = 0;
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || led !== 8'h01 || err_cnt !== 4'h0 ||
            fail_mask !== 8'h00 || pass !== 1'b0) begin
            n_bad++;
            $display("FAIL held_restart busy=%b led=%h err=%0d mask=%h pass=%b want 1/01/0/00/0",
                     busy, led, err_cnt, fail_mask, pass);
        end
        dones = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        n_cmp++;
        if (dones != 1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL held_second dones=%0d busy=%b want 1/0", dones, busy);
        end
        check_results("held_second", 8'h00, 4'd0, 1'b1);
    endtask
`endif

    task automatic test_reset_mid;
        int dones;
        mode = 2;
        do_reset();
        launch(1'b0);
        repeat (4 * 11 + 5) @(negedge clk);
        n_cmp++;
        if (led !== 8'h10 || fail_mask !== 8'h0B) begin
            n_bad++;
            $display("FAIL mid_pre led=%h mask=%h want 10/0b", led, fail_mask);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("mid_async");
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        n_cmp++;
        if (dones != 0) begin
            n_bad++;
            $display("FAIL mid_quiet activity=%0d want 0", dones);
        end
        mode = 0;
        launch(1'b0);
        watch_sweep("mid_clean");
        check_results("mid_clean", 8'h00, 4'd0, 1'b1);
    endtask

`ifdef FUN_SWEEP_LOOP_EN
    task automatic test_loop;
        int last;
        int seen;
        mode = 2;
        do_reset();
        launch(1'b0);
        last = -1;
        seen = 0;
        for (int k = 0; k < 4 * 89; k++) begin
            if (done === 1'b1) begin
                n_cmp++;
                if (k != 88 + seen * 89) begin
                    n_bad++;
                    $display("FAIL loop_done k=%0d want %0d", k, 88 + seen * 89);
                end
                seen++;
                last = k;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (seen != 4 || last != 355) begin
            n_bad++;
            $display("FAIL loop_count dones=%0d last=%0d want 4/355", seen, last);
        end
        check_results("loop", 8'hAB, 4'd15, 1'b0);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL loop_running busy=%b want 1", busy);
        end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_bad = 0;
        mode  = 0;
        rst_n = 1'b0;
        start = 1'b0;
        test_reset();
        test_sweep("golden", 0, 8'h00, 4'd0, 1'b1);
        test_sweep("tied0",  1, 8'h54, 4'd3, 1'b0);
        test_sweep("tied1",  2, 8'hAB, 4'd5, 1'b0);
`ifndef FUN_SWEEP_LOOP_EN
        test_start_held();
`endif
        test_reset_mid();
`ifdef FUN_SWEEP_LOOP_EN
        test_loop();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
